// File: rtl/iic_pkg.sv
// Shared definitions for the IIC request arbiter: FSM encoding and default
// EEPROM timing constants (50 MHz clock).
package iic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } iic_state_t;

  // 5 ms EEPROM internal write time, and a 20 ms abort window
  localparam int WR_GAP_DEF  = 250000;
  localparam int TIMEOUT_DEF = 1000000;

endpackage

// File: rtl/iic_arb_if.sv
// Command/response bundle between the arbiter and the IIC bit-level driver.
// Handshake: the master raises IIC_en with a stable command and holds it until
// the first Scl4x rising edge; the driver then reports completion with a rising
// edge on IIC_done, read data being valid in that cycle. Command fields stay
// stable until the next grant.
interface iic_arb_if;
  logic        IIC_en;
  logic [6:0]  IIC_slave_addr;
  logic [15:0] IIC_dev_addr;
  logic        IIC_bit_sel;
  logic        IIC_rh_wl;
  logic [7:0]  IIC_write_data;
  logic [7:0]  IIC_read_data;
  logic        IIC_done;
  logic        Scl4x;

  modport master (
    output IIC_en, IIC_slave_addr, IIC_dev_addr, IIC_bit_sel, IIC_rh_wl,
           IIC_write_data,
    input  IIC_read_data, IIC_done, Scl4x
  );

  modport slave (
    input  IIC_en, IIC_slave_addr, IIC_dev_addr, IIC_bit_sel, IIC_rh_wl,
           IIC_write_data,
    output IIC_read_data, IIC_done, Scl4x
  );
endinterface

// File: rtl/iic_rr_arb2.sv
// Two-input round-robin grant. last_q remembers the last winner; on contention
// the other requester wins. Reset value 1 lets requester 0 win first.
module iic_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_idx,
  output logic       gnt_valid
);

  logic last_q;

  always_comb begin
    gnt_idx = 1'b0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_q;
      default: gnt_idx = 1'b0;
    endcase
    gnt_valid = en & (|req);
    gnt       = gnt_valid ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst)            last_q <= 1'b1;
    else if (gnt_valid) last_q <= gnt_idx;
  end

endmodule

// File: rtl/iic_arb.sv
// Arbitrates two requesters onto one IIC driver: round-robin grant, command
// issue, completion/timeout reporting and post-write EEPROM idle gap.
module iic_arb
  import iic_pkg::*;
#(
  parameter int WR_GAP  = WR_GAP_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [1:0]       Req_en,
  input  logic [13:0]      Req_slave_addr,
  input  logic [31:0]      Req_dev_addr,
  input  logic [1:0]       Req_bit_sel,
  input  logic [1:0]       Req_rh_wl,
  input  logic [15:0]      Req_wdata,
  output logic [1:0]       Req_ack,
  output logic [1:0]       Req_done,
  output logic [1:0]       Req_err,
  output logic [7:0]       Req_rdata,
  output logic             Busy,
  output iic_state_t       state_dbg,
  iic_arb_if.master        iic
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(WR_GAP + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] G_LAST = GW'(WR_GAP - 1);

  iic_state_t    state_q, state_d;
  logic [TW-1:0] tcnt_q;
  logic [GW-1:0] gcnt_q;
  logic          scl_q, done_q, idx_q;
  logic          scl_rise, done_rise, t_last, g_last;
  logic          do_grant, do_done, do_err, clr_en;
  logic [1:0]    gnt;
  logic          gnt_idx, gnt_valid;

  iic_rr_arb2 u_rr (
    .clk       (Clk),
    .rst       (Rst),
    .req       (Req_en),
    .en        (state_q == IDLE),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign scl_rise  = iic.Scl4x & ~scl_q;
  assign done_rise = iic.IIC_done & ~done_q;
  assign t_last    = (tcnt_q == T_LAST);
  assign g_last    = (gcnt_q == G_LAST);
  assign Busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Completion wins over timeout when both land in the same cycle.
  always_comb begin
    state_d  = state_q;
    do_grant = 1'b0;
    do_done  = 1'b0;
    do_err   = 1'b0;
    clr_en   = 1'b0;
    case (state_q)
      IDLE: if (gnt_valid) begin
        do_grant = 1'b1;
        state_d  = ISSUE;
      end
      ISSUE: if (t_last) begin
        do_err  = 1'b1;
        state_d = IDLE;
      end else if (scl_rise) begin
        clr_en  = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (done_rise) begin
        do_done = 1'b1;
        state_d = iic.IIC_rh_wl ? IDLE : GAP;
      end else if (t_last) begin
        do_err  = 1'b1;
        state_d = IDLE;
      end
      GAP: if (g_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Req_ack            <= '0;
      Req_done           <= '0;
      Req_err            <= '0;
      Req_rdata          <= '0;
      iic.IIC_en         <= 1'b0;
      iic.IIC_slave_addr <= '0;
      iic.IIC_dev_addr   <= '0;
      iic.IIC_bit_sel    <= 1'b0;
      iic.IIC_rh_wl      <= 1'b0;
      iic.IIC_write_data <= '0;
      idx_q              <= 1'b0;
      tcnt_q             <= '0;
      gcnt_q             <= '0;
      scl_q              <= 1'b0;
      done_q             <= 1'b0;
    end else begin
      scl_q    <= iic.Scl4x;
      done_q   <= iic.IIC_done;
      Req_ack  <= gnt;
      Req_done <= do_done ? {idx_q, ~idx_q} : 2'b00;
      Req_err  <= do_err  ? {idx_q, ~idx_q} : 2'b00;
      if (do_grant) begin
        idx_q              <= gnt_idx;
        iic.IIC_en         <= 1'b1;
        iic.IIC_slave_addr <= gnt_idx ? Req_slave_addr[13:7] : Req_slave_addr[6:0];
        iic.IIC_dev_addr   <= gnt_idx ? Req_dev_addr[31:16]  : Req_dev_addr[15:0];
        iic.IIC_bit_sel    <= Req_bit_sel[gnt_idx];
        iic.IIC_rh_wl      <= Req_rh_wl[gnt_idx];
        iic.IIC_write_data <= gnt_idx ? Req_wdata[15:8] : Req_wdata[7:0];
      end else if (clr_en || do_err) begin
        iic.IIC_en <= 1'b0;
      end
      if (do_done && iic.IIC_rh_wl) Req_rdata <= iic.IIC_read_data;
      // Both counters saturate rather than wrap.
      if (do_grant)            tcnt_q <= '0;
      else if (tcnt_q != '1)   tcnt_q <= tcnt_q + 1'b1;
      if (state_q != GAP)      gcnt_q <= '0;
      else if (gcnt_q != '1)   gcnt_q <= gcnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_iic_arb.sv
// Directed bench for iic_arb with a hand-driven IIC driver model
// (WR_GAP = 20, TIMEOUT = 100).
module tb_iic_arb;
  import iic_pkg::*;

  localparam int WR_GAP  = 20;
  localparam int TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_en;
  logic [13:0] req_slave_addr;
  logic [31:0] req_dev_addr;
  logic [1:0]  req_bit_sel;
  logic [1:0]  req_rh_wl;
  logic [15:0] req_wdata;
  logic [1:0]  req_ack, req_done, req_err;
  logic [7:0]  req_rdata;
  logic        busy;
  iic_state_t  state_dbg;
  int          n_vec = 0;
  int          n_err = 0;

  iic_arb_if bus ();

  iic_arb #(.WR_GAP(WR_GAP), .TIMEOUT(TIMEOUT)) dut (
    .Clk            (clk),
    .Rst            (rst),
    .Req_en         (req_en),
    .Req_slave_addr (req_slave_addr),
    .Req_dev_addr   (req_dev_addr),
    .Req_bit_sel    (req_bit_sel),
    .Req_rh_wl      (req_rh_wl),
    .Req_wdata      (req_wdata),
    .Req_ack        (req_ack),
    .Req_done       (req_done),
    .Req_err        (req_err),
    .Req_rdata      (req_rdata),
    .Busy           (busy),
    .state_dbg      (state_dbg),
    .iic            (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: Scl4x rise then IIC_done rise; leaves the bench in the done cycle
  task automatic finish_txn();
    bus.Scl4x = 1'b1;
    tick();
    bus.Scl4x    = 1'b0;
    bus.IIC_done = 1'b1;
    tick();
    bus.IIC_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_en = '0; req_slave_addr = '0; req_dev_addr = '0;
    req_bit_sel = '0; req_rh_wl = '0; req_wdata = '0;
    bus.IIC_read_data = 8'hA5; bus.IIC_done = 1'b0; bus.Scl4x = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_vec++;
    if ({busy, req_ack, req_done, req_err, req_rdata} !== 15'h0) begin
      $display("FAIL reset_outputs: got %h expected 0", {busy, req_ack, req_done, req_err, req_rdata}); n_err++;
    end
    n_vec++;
    if ({bus.IIC_en, bus.IIC_slave_addr, bus.IIC_dev_addr, bus.IIC_write_data} !== 32'h0) begin
      $display("FAIL reset_iic: got %h expected 0", {bus.IIC_en, bus.IIC_slave_addr, bus.IIC_dev_addr, bus.IIC_write_data}); n_err++;
    end
    n_vec++;
    if (state_dbg !== IDLE) begin
      $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE); n_err++;
    end
  endtask

  task automatic test_write();
    int busy_cnt;
    req_en = 2'b01; req_slave_addr[6:0] = 7'h50; req_dev_addr[15:0] = 16'h0A5A;
    req_bit_sel[0] = 1'b1; req_rh_wl[0] = 1'b0; req_wdata[7:0] = 8'h5A;
    tick();
    req_en = 2'b00;
    n_vec++;
    if (req_ack !== 2'b01 || state_dbg !== ISSUE || busy !== 1'b1) begin
      $display("FAIL wr_ack: got ack=%b st=%0d busy=%b expected ack=01 st=1 busy=1", req_ack, state_dbg, busy); n_err++;
    end
    n_vec++;
    if ({bus.IIC_en, bus.IIC_slave_addr, bus.IIC_dev_addr, bus.IIC_bit_sel, bus.IIC_rh_wl, bus.IIC_write_data}
        !== {1'b1, 7'h50, 16'h0A5A, 1'b1, 1'b0, 8'h5A}) begin
      $display("FAIL wr_cmd: got en=%b sa=%h da=%h bs=%b rw=%b wd=%h expected 1 50 0a5a 1 0 5a", bus.IIC_en,
               bus.IIC_slave_addr, bus.IIC_dev_addr, bus.IIC_bit_sel, bus.IIC_rh_wl, bus.IIC_write_data); n_err++;
    end
    tick(); tick(); tick();
    n_vec++;
    if (bus.IIC_en !== 1'b1 || req_ack !== 2'b00) begin
      $display("FAIL wr_en_hold: got en=%b ack=%b expected en=1 ack=00", bus.IIC_en, req_ack); n_err++;
    end
    bus.Scl4x = 1'b1;
    tick();
    bus.Scl4x = 1'b0;
    n_vec++;
    if (bus.IIC_en !== 1'b0 || state_dbg !== WAIT) begin
      $display("FAIL wr_en_drop: got en=%b st=%0d expected en=0 st=2", bus.IIC_en, state_dbg); n_err++;
    end
    tick();
    bus.IIC_done = 1'b1;
    tick();
    bus.IIC_done = 1'b0;
    n_vec++;
    if (req_done !== 2'b01 || state_dbg !== GAP || req_rdata !== 8'h00) begin
      $display("FAIL wr_done: got done=%b st=%0d rd=%h expected done=01 st=3 rd=00", req_done, state_dbg, req_rdata); n_err++;
    end
    busy_cnt = 1;
    for (int i = 0; i < 40 && busy; i++) begin
      tick();
      if (busy) busy_cnt++;
    end
    n_vec++;
    if (busy_cnt !== WR_GAP || state_dbg !== IDLE) begin
      $display("FAIL wr_gap_len: got %0d cycles st=%0d expected %0d cycles st=0", busy_cnt, state_dbg, WR_GAP); n_err++;
    end
  endtask

  task automatic test_read();
    req_en = 2'b10; req_slave_addr[13:7] = 7'h51; req_dev_addr[31:16] = 16'h0ADA;
    req_bit_sel[1] = 1'b1; req_rh_wl[1] = 1'b1; req_wdata[15:8] = 8'h00;
    bus.IIC_read_data = 8'hA5;
    tick();
    req_en = 2'b00;
    n_vec++;
    if (req_ack !== 2'b10 || bus.IIC_slave_addr !== 7'h51 || bus.IIC_dev_addr !== 16'h0ADA || bus.IIC_rh_wl !== 1'b1) begin
      $display("FAIL rd_ack: got ack=%b sa=%h da=%h rw=%b expected 10 51 0ada 1", req_ack, bus.IIC_slave_addr,
               bus.IIC_dev_addr, bus.IIC_rh_wl); n_err++;
    end
    finish_txn();
    n_vec++;
    if (req_done !== 2'b10 || req_rdata !== 8'hA5 || state_dbg !== IDLE || busy !== 1'b0) begin
      $display("FAIL rd_done: got done=%b rd=%h st=%0d busy=%b expected 10 a5 0 0", req_done, req_rdata, state_dbg, busy); n_err++;
    end
    bus.IIC_read_data = 8'h3C;
    tick(); tick();
    n_vec++;
    if (req_rdata !== 8'hA5 || req_done !== 2'b00) begin
      $display("FAIL rd_hold: got rd=%h done=%b expected a5 00", req_rdata, req_done); n_err++;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_gnt [4];
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
    req_rh_wl = 2'b11;
    for (int r = 0; r < 2; r++) begin
      req_en = 2'b11;
      for (int k = 0; k < 2; k++) begin
        tick();
        n_vec++;
        if (req_ack !== exp_gnt[2*r+k]) begin
          $display("FAIL rr_grant%0d: got %b expected %b", 2*r+k, req_ack, exp_gnt[2*r+k]); n_err++;
        end
        req_en = req_en & ~req_ack;
        finish_txn();
        n_vec++;
        if (req_done !== exp_gnt[2*r+k]) begin
          $display("FAIL rr_done%0d: got %b expected %b", 2*r+k, req_done, exp_gnt[2*r+k]); n_err++;
        end
      end
    end
  endtask

  task automatic test_timeout();
    int early;
    req_en = 2'b01; req_rh_wl[0] = 1'b0;
    tick();
    req_en = 2'b00;
    early = 0;
    bus.Scl4x = 1'b1;
    for (int i = 1; i < TIMEOUT; i++) begin
      tick();
      bus.Scl4x = 1'b0;
      if (req_err !== 2'b00 || req_done !== 2'b00) early++;
    end
    n_vec++;
    if (early !== 0) begin
      $display("FAIL to_early: got %0d early pulses expected 0", early); n_err++;
    end
    tick();
    n_vec++;
    if (req_err !== 2'b01 || bus.IIC_en !== 1'b0 || state_dbg !== IDLE || req_done !== 2'b00) begin
      $display("FAIL to_err: got err=%b en=%b st=%0d done=%b expected 01 0 0 00", req_err, bus.IIC_en, state_dbg, req_done); n_err++;
    end
    tick();
    n_vec++;
    if (req_err !== 2'b00) begin
      $display("FAIL to_pulse: got %b expected 00", req_err); n_err++;
    end
  endtask

  task automatic test_reset_mid();
    req_en = 2'b01; req_rh_wl[0] = 1'b1;
    tick();
    req_en = 2'b00;
    bus.Scl4x = 1'b1;
    tick();
    bus.Scl4x = 1'b0;
    n_vec++;
    if (state_dbg !== WAIT) begin
      $display("FAIL rst_mid_wait: got %0d expected %0d", state_dbg, WAIT); n_err++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({busy, req_ack, req_done, req_err, req_rdata, bus.IIC_en, bus.IIC_dev_addr} !== 32'h0) begin
      $display("FAIL rst_mid_out: got %h expected 0", {busy, req_ack, req_done, req_err, req_rdata, bus.IIC_en, bus.IIC_dev_addr}); n_err++;
    end
    bus.IIC_done = 1'b1;
    tick();
    bus.IIC_done = 1'b0;
    n_vec++;
    if (req_done !== 2'b00 || state_dbg !== IDLE) begin
      $display("FAIL rst_mid_late_done: got done=%b st=%0d expected 00 0", req_done, state_dbg); n_err++;
    end
    req_en = 2'b10;
    tick();
    req_en = 2'b00;
    n_vec++;
    if (req_ack !== 2'b10) begin
      $display("FAIL rst_mid_next_ack: got %b expected 10", req_ack); n_err++;
    end
    finish_txn();
    n_vec++;
    if (req_done !== 2'b10 || req_rdata !== 8'h3C) begin
      $display("FAIL rst_mid_next_done: got done=%b rd=%h expected 10 3c", req_done, req_rdata); n_err++;
    end
  endtask

  task automatic test_done_ignored();
    int waited;
    tick();
    bus.IIC_done = 1'b1;
    tick();
    bus.IIC_done = 1'b0;
    n_vec++;
    if (req_done !== 2'b00 || state_dbg !== IDLE) begin
      $display("FAIL ign_idle: got done=%b st=%0d expected 00 0", req_done, state_dbg); n_err++;
    end
    tick();
    req_en = 2'b01; req_rh_wl[0] = 1'b0;
    tick();
    req_en = 2'b00;
    finish_txn();
    tick(); tick();
    req_en = 2'b10;
    bus.IIC_done = 1'b1;
    tick();
    bus.IIC_done = 1'b0;
    n_vec++;
    if (req_done !== 2'b00 || state_dbg !== GAP || req_ack !== 2'b00) begin
      $display("FAIL ign_gap: got done=%b st=%0d ack=%b expected 00 3 00", req_done, state_dbg, req_ack); n_err++;
    end
    waited = 0;
    while (state_dbg == GAP && waited < 40) begin
      tick();
      waited++;
    end
    n_vec++;
    if (state_dbg !== IDLE || req_ack !== 2'b00) begin
      $display("FAIL ign_gap_end: got st=%0d ack=%b after %0d cycles expected 0 00", state_dbg, req_ack, waited); n_err++;
    end
    tick();
    req_en = 2'b00;
    n_vec++;
    if (req_ack !== 2'b10) begin
      $display("FAIL ign_pending_ack: got %b expected 10", req_ack); n_err++;
    end
    finish_txn();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_done_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iic_arb.md
IIC_ARB -- requirements
Module: iic_arb

Interface
REQ-001 Parameter WR_GAP, default 250000, Clk cycles of idle enforced after each completed write (EEPROM internal write time, 5 ms at 50 MHz).
REQ-002 Parameter TIMEOUT, default 1000000, Clk cycles allowed from issue to IIC_done before abort.
REQ-003 Clk  input  1  system clock, 50 MHz.
REQ-004 Rst  input  1  synchronous reset, active-high.
REQ-005 Req_en  input  2  per-requester request level; bit i belongs to requester i; held until Req_ack[i].
REQ-006 Req_slave_addr  input  14  requester i in bits [7i+6:7i].
REQ-007 Req_dev_addr  input  32  requester i in bits [16i+15:16i].
REQ-008 Req_bit_sel  input  2  device address width per requester; 0 = 8 bit, 1 = 16 bit.
REQ-009 Req_rh_wl  input  2  per requester; 0 = write, 1 = read.
REQ-010 Req_wdata  input  16  requester i in bits [8i+7:8i].
REQ-011 Req_ack  output  2  one-cycle pulse when the request is granted and latched.
REQ-012 Req_done  output  2  one-cycle pulse on transaction completion to the granted requester.
REQ-013 Req_err  output  2  one-cycle pulse on timeout to the granted requester.
REQ-014 Req_rdata  output  8  read data, valid in the Req_done cycle, held until the next completion.
REQ-015 Busy  output  1  high in every state except IDLE.
REQ-016 IIC_en, IIC_slave_addr[6:0], IIC_dev_addr[15:0], IIC_bit_sel, IIC_rh_wl, IIC_write_data[7:0]  outputs  command to the IIC driver.
REQ-017 IIC_read_data[7:0], IIC_done, Scl4x  inputs  from the IIC driver; all synchronous to Clk.

Function
REQ-018 States: IDLE, ISSUE, WAIT, GAP.
REQ-019 IDLE: any Req_en bit set -> grant, pulse Req_ack of the granted requester, latch its command fields into the IIC_* outputs, go to ISSUE in the next cycle.
REQ-020 Arbitration is round-robin: when both request, grant the requester not granted last; the pointer resets to 1, so requester 0 wins the first contention.
REQ-021 ISSUE: IIC_en = 1 until the first Scl4x rising edge (Scl4x=1, previous sample 0), then IIC_en = 0 in the next cycle and go to WAIT.
REQ-022 WAIT: on an IIC_done rising edge, pulse Req_done, capture IIC_read_data into Req_rdata (reads only; writes leave it unchanged), then go to GAP for writes and IDLE for reads.
REQ-023 The timeout counter starts on entry to ISSUE; on reaching TIMEOUT-1 without an IIC_done rise, pulse Req_err instead of Req_done, drive IIC_en = 0, and go to IDLE.
REQ-024 GAP: count WR_GAP cycles, then go to IDLE; requests arriving during GAP stay pending and receive no Req_ack.
REQ-025 IIC_* command outputs remain stable from grant until the next grant.
REQ-026 An IIC_done rise outside WAIT is ignored.
REQ-027 Req_en deasserted after Req_ack does not abort the transaction.
REQ-028 Counters are wide enough for their parameter and saturate; they never wrap.

Reset
REQ-029 When Rst is high on a Clk edge: state = IDLE; all outputs = 0; counters = 0; edge-detect registers = 0; round-robin pointer = 1.
REQ-030 Reset in any state, including mid-transaction, aborts the transaction with no Req_done or Req_err pulse.

Structure
REQ-031 The state encoding, the WR_GAP default and the TIMEOUT default live in shared package iic_pkg.
REQ-032 There is one sub-module, iic_rr_arb2: a two-input round-robin grant with pointer update on grant.

Verification
REQ-033 Requester 0 writes 0x5A to 16-bit address 0x0A5A, slave address 0x50 -> Req_ack[0] pulse, IIC_en held until the Scl4x rise, Req_done[0] pulse, then Busy stays high for WR_GAP cycles.
REQ-034 Requester 1 reads 16-bit address 0x0ADA while the model returns 0xA5 -> Req_done[1] pulse, Req_rdata = 0xA5, no GAP state.
REQ-035 Both requesters request in the same cycle on two consecutive rounds -> grant order 0, 1, 0, 1.
REQ-036 Model never raises IIC_done, TIMEOUT = 100 -> Req_err pulse 100 cycles after ISSUE entry, IIC_en = 0, return to IDLE.
REQ-037 Rst asserted during WAIT -> all outputs 0 next cycle, no Req_done, and the next request is served normally.
REQ-038 IIC_done pulsed while in IDLE and while in GAP -> no Req_done pulse and no state change.
